// File: rtl/accel_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// accel_mem_arbiter_if
//   Bundles the requester-side handshake buses and the RAM-port buses that
//   accel_mem_arbiter sits between. Per-requester buses are flattened, with
//   requester i occupying slice i.
//
//   Requester side : req_i, we_i, addr_i, be_i, wdata_i  (requesters -> arbiter)
//                    gnt_o, rvalid_o, err_o, rdata_o      (arbiter -> requesters)
//   Memory side    : mem_en_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
//                                                         (arbiter -> RAM port)
//                    mem_rdata_i                          (RAM port -> arbiter)
//
//   modport slave  : the arbiter's view.
//   modport master : the surrounding environment (requesters and RAM).
// -----------------------------------------------------------------------------
interface accel_mem_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   localparam int BEW = DATA_WIDTH / 8;

   // Requester side
   logic [NUM_REQ-1:0]            req_i;
   logic [NUM_REQ-1:0]            we_i;
   logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
   logic [NUM_REQ*BEW-1:0]        be_i;
   logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
   logic [NUM_REQ-1:0]            gnt_o;
   logic [NUM_REQ-1:0]            rvalid_o;
   logic [NUM_REQ-1:0]            err_o;
   logic [DATA_WIDTH-1:0]         rdata_o;

   // Memory side
   logic                          mem_en_o;
   logic                          mem_we_o;
   logic [ADDR_WIDTH-1:0]         mem_addr_o;
   logic [BEW-1:0]                mem_be_o;
   logic [DATA_WIDTH-1:0]         mem_wdata_o;
   logic [DATA_WIDTH-1:0]         mem_rdata_i;

   modport slave (
      input  req_i, we_i, addr_i, be_i, wdata_i, mem_rdata_i,
      output gnt_o, rvalid_o, err_o, rdata_o,
      output mem_en_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
   );

   modport master (
      output req_i, we_i, addr_i, be_i, wdata_i, mem_rdata_i,
      input  gnt_o, rvalid_o, err_o, rdata_o,
      input  mem_en_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
   );
endinterface

// File: rtl/accel_mem_arbiter.sv
// -----------------------------------------------------------------------------
// accel_mem_arbiter
//   Shares one RAM port between NUM_REQ requesters (index 0 = CPU). Grants are
//   combinational (same cycle as the request) using a round-robin pointer, with
//   an optional exclusive-owner mode. Out-of-range addresses are granted but
//   never reach the RAM; they answer with err=1. Every grant produces exactly
//   one response READ_LATENCY cycles later, in grant order.
//
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     excl_en       : exclusive mode, only excl_id may be granted
//     excl_id       : exclusive owner (values >= NUM_REQ grant nothing)
//     busy_o        : a response is still in flight
//     bus (slave)   : requester handshakes and RAM port, see accel_mem_arbiter_if
// -----------------------------------------------------------------------------
module accel_mem_arbiter #(
   parameter int  NUM_REQ      = 2,
   parameter int  ADDR_WIDTH   = 10,
   parameter int  DATA_WIDTH   = 32,
   parameter int  DEPTH        = 1024,
   parameter int  READ_LATENCY = 1,
   localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  excl_en,
   input  logic [IDW-1:0]        excl_id,
   output logic                  busy_o,
   accel_mem_arbiter_if.slave    bus
);

   localparam int                BEW     = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [IDW:0]      NREQ_L  = (IDW + 1)'(NUM_REQ);
   localparam logic [IDW-1:0]    LAST_ID = IDW'(NUM_REQ - 1);

   // One slot of the response pipeline
   typedef struct packed {
      logic           vld;
      logic [IDW-1:0] id;
      logic           err;
      logic           rd;
   } rsp_t;

   logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
   rsp_t                  rsp_q [READ_LATENCY];
   rsp_t                  rsp_d;
   rsp_t                  rsp_last;

   logic [NUM_REQ-1:0]    excl_mask;
   logic [NUM_REQ-1:0]    elig;
   logic [NUM_REQ-1:0]    elig_rot;
   logic                  win_found;
   logic [IDW-1:0]        win_off;
   logic [IDW-1:0]        win_id;
   logic                  win_we;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [BEW-1:0]        win_be;
   logic [DATA_WIDTH-1:0] win_wdata;
   logic                  grant;
   logic                  in_range;

   // ---------------------------------------------------------------------------
   // Eligibility: an out-of-range excl_id matches no requester, so nothing wins.
   // ---------------------------------------------------------------------------
   always_comb begin
      excl_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         excl_mask[i] = (excl_id == IDW'(i));
      end
      elig = excl_en ? (bus.req_i & excl_mask) : bus.req_i;
   end

   // ---------------------------------------------------------------------------
   // Round-robin search: rotate the eligible vector so rr_ptr lands on bit 0,
   // take the lowest set bit, then add rr_ptr back modulo NUM_REQ.
   // ---------------------------------------------------------------------------
   always_comb begin
      logic [2*NUM_REQ-1:0] dbl;
      logic [IDW:0]         sum;
      dbl       = {elig, elig} >> rr_ptr_q;
      elig_rot  = dbl[NUM_REQ-1:0];
      win_found = |elig_rot;
      win_off   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (elig_rot[i]) begin
            win_off = IDW'(i);
         end
      end
      sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
      if (sum >= NREQ_L) begin
         sum = sum - NREQ_L;
      end
      win_id = sum[IDW-1:0];
   end

   // ---------------------------------------------------------------------------
   // Winner payload mux
   // ---------------------------------------------------------------------------
   always_comb begin
      win_we    = 1'b0;
      win_addr  = '0;
      win_be    = '0;
      win_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_id == IDW'(i)) begin
            win_we    = bus.we_i[i];
            win_addr  = bus.addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            win_be    = bus.be_i[i*BEW +: BEW];
            win_wdata = bus.wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Reset gates the combinational grant so every output is 0 while rst=1.
   assign grant    = win_found & ~rst;
   assign in_range = ({1'b0, win_addr} < DEPTH_L);

   // ---------------------------------------------------------------------------
   // Grant and memory port drive
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.gnt_o       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.gnt_o[i] = grant & (win_id == IDW'(i));
      end
      bus.mem_en_o    = grant & in_range;
      bus.mem_we_o    = grant & in_range & win_we;
      bus.mem_addr_o  = (grant & in_range) ? win_addr  : '0;
      bus.mem_be_o    = (grant & in_range) ? win_be    : '0;
      bus.mem_wdata_o = (grant & in_range) ? win_wdata : '0;
   end

   // ---------------------------------------------------------------------------
   // Next-state: pointer moves past the winner on any grant, including grants
   // made in exclusive mode, so fairness resumes from the owner's successor.
   // ---------------------------------------------------------------------------
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant) begin
         rr_ptr_d = (win_id == LAST_ID) ? '0 : (win_id + IDW'(1));
      end
      rsp_d.vld = grant;
      rsp_d.id  = win_id;
      rsp_d.err = grant & ~in_range;
      rsp_d.rd  = grant & ~win_we;
   end

   // ---------------------------------------------------------------------------
   // Response pipeline: stage 0 loads on each grant, later stages shift.
   // Reset clears every stage so in-flight responses are dropped.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q <= '0;
         for (int s = 0; s < READ_LATENCY; s++) begin
            rsp_q[s] <= '0;
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         rsp_q[0] <= rsp_d;
         for (int s = 1; s < READ_LATENCY; s++) begin
            rsp_q[s] <= rsp_q[s-1];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Response outputs from the last stage
   // ---------------------------------------------------------------------------
   assign rsp_last = rsp_q[READ_LATENCY-1];

   always_comb begin
      bus.rvalid_o = '0;
      bus.err_o    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.rvalid_o[i] = rsp_last.vld & (rsp_last.id == IDW'(i));
         bus.err_o[i]    = rsp_last.vld & rsp_last.err & (rsp_last.id == IDW'(i));
      end
      // Errors and writes return zero data rather than whatever the RAM holds.
      bus.rdata_o = (rsp_last.vld & rsp_last.rd & ~rsp_last.err) ? bus.mem_rdata_i : '0;
   end

   always_comb begin
      busy_o = 1'b0;
      for (int s = 0; s < READ_LATENCY; s++) begin
         busy_o = busy_o | rsp_q[s].vld;
      end
   end

endmodule

// File: tb/tb_accel_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_accel_mem_arbiter
//   Three arbiter instances share clk/rst:
//     a : NUM_REQ=2, DEPTH=42, READ_LATENCY=1  (table-driven vectors)
//     b : NUM_REQ=3, DEPTH=1024, READ_LATENCY=1 (round-robin, exclusive edge)
//     c : NUM_REQ=2, DEPTH=1024, READ_LATENCY=2 (latency 2, reset mid-flight)
//   Each instance gets a small behavioural RAM behind its memory port.
// -----------------------------------------------------------------------------
module tb_accel_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------------------------------------------------------- DUT a
   accel_mem_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(10), .DATA_WIDTH(32)) ifa ();
   logic       xen_a;
   logic [0:0] xid_a;
   logic       busy_a;
   accel_mem_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(10), .DATA_WIDTH(32),
                       .DEPTH(42), .READ_LATENCY(1)) dut_a (
      .clk(clk), .rst(rst), .excl_en(xen_a), .excl_id(xid_a),
      .busy_o(busy_a), .bus(ifa));

   // ---------------------------------------------------------------- DUT b
   accel_mem_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(10), .DATA_WIDTH(32)) ifb ();
   logic       xen_b;
   logic [1:0] xid_b;
   logic       busy_b;
   accel_mem_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(10), .DATA_WIDTH(32),
                       .DEPTH(1024), .READ_LATENCY(1)) dut_b (
      .clk(clk), .rst(rst), .excl_en(xen_b), .excl_id(xid_b),
      .busy_o(busy_b), .bus(ifb));

   // ---------------------------------------------------------------- DUT c
   accel_mem_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(10), .DATA_WIDTH(32)) ifc ();
   logic       xen_c;
   logic [0:0] xid_c;
   logic       busy_c;
   accel_mem_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(10), .DATA_WIDTH(32),
                       .DEPTH(1024), .READ_LATENCY(2)) dut_c (
      .clk(clk), .rst(rst), .excl_en(xen_c), .excl_id(xid_c),
      .busy_o(busy_c), .bus(ifc));

   // ---------------------------------------------------------------- RAMs
   logic [31:0] mem_a [1024];
   logic [31:0] mem_c [1024];
   logic [31:0] rda1, rdc1, rdc2;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = 32'hA500_0000 | 32'(i);
         mem_c[i] = 32'hA500_0000 | 32'(i);
      end
   end

   always @(posedge clk) begin
      if (ifa.mem_en_o) begin
         if (ifa.mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (ifa.mem_be_o[b]) mem_a[ifa.mem_addr_o][8*b +: 8] <= ifa.mem_wdata_o[8*b +: 8];
         end else begin
            rda1 <= mem_a[ifa.mem_addr_o];
         end
      end
   end

   always @(posedge clk) begin
      if (ifc.mem_en_o && !ifc.mem_we_o) rdc1 <= mem_c[ifc.mem_addr_o];
      rdc2 <= rdc1;
   end

   assign ifa.mem_rdata_i = rda1;
   assign ifb.mem_rdata_i = 32'h0;
   assign ifc.mem_rdata_i = rdc2;

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic [1:0]  req;
      logic [1:0]  we;
      logic [9:0]  a0;
      logic [9:0]  a1;
      logic [3:0]  be1;
      logic [31:0] wd0;
      logic [31:0] wd1;
      logic        xen;
      logic        xid;
      logic [1:0]  gnt;
      logic        men;
      logic [9:0]  maddr;
      logic [1:0]  rv;
      logic [1:0]  er;
      logic [31:0] rd;
      logic        busy;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [1:0] req, input logic [1:0] we,
                      input logic [9:0] a0, input logic [9:0] a1,
                      input logic [3:0] be1, input logic [31:0] wd0,
                      input logic [31:0] wd1, input logic xen, input logic xid,
                      input logic [1:0] gnt, input logic men,
                      input logic [9:0] maddr, input logic [1:0] rv,
                      input logic [1:0] er, input logic [31:0] rd,
                      input logic busy);
      vec_t v;
      v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.be1 = be1;
      v.wd0 = wd0; v.wd1 = wd1; v.xen = xen; v.xid = xid;
      v.gnt = gnt; v.men = men; v.maddr = maddr; v.rv = rv; v.er = er;
      v.rd = rd; v.busy = busy;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_all();
      ifa.req_i = '0; ifa.we_i = '0; ifa.addr_i = '0; ifa.be_i = '0; ifa.wdata_i = '0;
      ifb.req_i = '0; ifb.we_i = '0; ifb.addr_i = '0; ifb.be_i = '0; ifb.wdata_i = '0;
      ifc.req_i = '0; ifc.we_i = '0; ifc.addr_i = '0; ifc.be_i = '0; ifc.wdata_i = '0;
      xen_a = 1'b0; xid_a = 1'b0; xen_b = 1'b0; xid_b = 2'd0; xen_c = 1'b0; xid_c = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   // ---------------------------------------------------------------- main
   initial begin
      logic [2:0] seq_b [6];
      seq_b[0] = 3'b001; seq_b[1] = 3'b010; seq_b[2] = 3'b100;
      seq_b[3] = 3'b001; seq_b[4] = 3'b010; seq_b[5] = 3'b100;

      //   req    we     a0      a1      be1   wd0           wd1           xen  xid | gnt  men  maddr   rv     er     rd            busy
      add(2'b01, 2'b01, 10'd5,  10'd0,  4'hF, 32'hDEADBEEF, 32'h0,        1'b0,1'b0, 2'b01,1'b1,10'd5,  2'b00, 2'b00, 32'h0,        1'b0);
      add(2'b00, 2'b00, 10'd0,  10'd0,  4'hF, 32'h0,        32'h0,        1'b0,1'b0, 2'b00,1'b0,10'd0,  2'b01, 2'b00, 32'h0,        1'b1);
      add(2'b01, 2'b00, 10'd5,  10'd0,  4'hF, 32'h0,        32'h0,        1'b0,1'b0, 2'b01,1'b1,10'd5,  2'b00, 2'b00, 32'h0,        1'b0);
      add(2'b00, 2'b00, 10'd0,  10'd0,  4'hF, 32'h0,        32'h0,        1'b0,1'b0, 2'b00,1'b0,10'd0,  2'b01, 2'b00, 32'hDEADBEEF, 1'b1);
      add(2'b11, 2'b00, 10'd6,  10'd7,  4'hF, 32'h0,        32'h0,        1'b1,1'b1, 2'b10,1'b1,10'd7,  2'b00, 2'b00, 32'h0,        1'b0);
      add(2'b11, 2'b00, 10'd6,  10'd7,  4'hF, 32'h0,        32'h0,        1'b1,1'b1, 2'b10,1'b1,10'd7,  2'b10, 2'b00, 32'hA5000007, 1'b1);
      add(2'b11, 2'b00, 10'd6,  10'd7,  4'hF, 32'h0,        32'h0,        1'b1,1'b1, 2'b10,1'b1,10'd7,  2'b10, 2'b00, 32'hA5000007, 1'b1);
      add(2'b11, 2'b00, 10'd6,  10'd7,  4'hF, 32'h0,        32'h0,        1'b1,1'b1, 2'b10,1'b1,10'd7,  2'b10, 2'b00, 32'hA5000007, 1'b1);
      add(2'b11, 2'b00, 10'd6,  10'd7,  4'hF, 32'h0,        32'h0,        1'b0,1'b0, 2'b01,1'b1,10'd6,  2'b10, 2'b00, 32'hA5000007, 1'b1);
      add(2'b00, 2'b00, 10'd0,  10'd0,  4'hF, 32'h0,        32'h0,        1'b0,1'b0, 2'b00,1'b0,10'd0,  2'b01, 2'b00, 32'hA5000006, 1'b1);
      add(2'b01, 2'b00, 10'd42, 10'd0,  4'hF, 32'h0,        32'h0,        1'b0,1'b0, 2'b01,1'b0,10'd0,  2'b00, 2'b00, 32'h0,        1'b0);
      add(2'b01, 2'b00, 10'd41, 10'd0,  4'hF, 32'h0,        32'h0,        1'b0,1'b0, 2'b01,1'b1,10'd41, 2'b01, 2'b01, 32'h0,        1'b1);
      add(2'b00, 2'b00, 10'd0,  10'd0,  4'hF, 32'h0,        32'h0,        1'b0,1'b0, 2'b00,1'b0,10'd0,  2'b01, 2'b00, 32'hA5000029, 1'b1);
      add(2'b10, 2'b10, 10'd0,  10'd50, 4'hF, 32'h0,        32'h12345678, 1'b0,1'b0, 2'b10,1'b0,10'd0,  2'b00, 2'b00, 32'h0,        1'b0);
      add(2'b00, 2'b00, 10'd0,  10'd0,  4'hF, 32'h0,        32'h0,        1'b0,1'b0, 2'b00,1'b0,10'd0,  2'b10, 2'b10, 32'h0,        1'b1);
      add(2'b10, 2'b10, 10'd0,  10'd5,  4'h3, 32'h0,        32'h11223344, 1'b0,1'b0, 2'b10,1'b1,10'd5,  2'b00, 2'b00, 32'h0,        1'b0);
      add(2'b10, 2'b00, 10'd0,  10'd5,  4'hF, 32'h0,        32'h0,        1'b0,1'b0, 2'b10,1'b1,10'd5,  2'b10, 2'b00, 32'h0,        1'b1);
      add(2'b00, 2'b00, 10'd0,  10'd0,  4'hF, 32'h0,        32'h0,        1'b0,1'b0, 2'b00,1'b0,10'd0,  2'b10, 2'b00, 32'hDEAD3344, 1'b1);
      add(2'b00, 2'b00, 10'd0,  10'd0,  4'hF, 32'h0,        32'h0,        1'b0,1'b0, 2'b00,1'b0,10'd0,  2'b00, 2'b00, 32'h0,        1'b0);

      // ---- reset state: requests held high must not be granted during reset
      idle_all();
      rst = 1'b1;
      ifa.req_i = 2'b11; ifb.req_i = 3'b111; ifc.req_i = 2'b11;
      @(negedge clk); #1;
      chk("rst_gnt_a",   32'(ifa.gnt_o),    32'h0);
      chk("rst_men_a",   32'(ifa.mem_en_o), 32'h0);
      chk("rst_rv_a",    32'(ifa.rvalid_o), 32'h0);
      chk("rst_busy_a",  32'(busy_a),       32'h0);
      chk("rst_gnt_b",   32'(ifb.gnt_o),    32'h0);
      chk("rst_gnt_c",   32'(ifc.gnt_o),    32'h0);
      @(negedge clk);
      idle_all();
      rst = 1'b0;

      // ---- table-driven vectors on instance a
      foreach (vq[i]) begin
         @(negedge clk);
         ifa.req_i   = vq[i].req;
         ifa.we_i    = vq[i].we;
         ifa.addr_i  = {vq[i].a1, vq[i].a0};
         ifa.be_i    = {vq[i].be1, 4'hF};
         ifa.wdata_i = {vq[i].wd1, vq[i].wd0};
         xen_a       = vq[i].xen;
         xid_a       = vq[i].xid;
         #1;
         chk($sformatf("v%0d_gnt", i),    32'(ifa.gnt_o),      32'(vq[i].gnt));
         chk($sformatf("v%0d_men", i),    32'(ifa.mem_en_o),   32'(vq[i].men));
         chk($sformatf("v%0d_maddr", i),  32'(ifa.mem_addr_o), 32'(vq[i].maddr));
         chk($sformatf("v%0d_rvalid", i), 32'(ifa.rvalid_o),   32'(vq[i].rv));
         chk($sformatf("v%0d_err", i),    32'(ifa.err_o),      32'(vq[i].er));
         chk($sformatf("v%0d_rdata", i),  ifa.rdata_o,         vq[i].rd);
         chk($sformatf("v%0d_busy", i),   32'(busy_a),         32'(vq[i].busy));
      end

      // ---- round-robin fairness on instance b (3 requesters)
      @(negedge clk);
      idle_all();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         ifb.req_i = 3'b111;
         #1;
         chk($sformatf("rr%0d_gnt", c),    32'(ifb.gnt_o),    32'(seq_b[c]));
         chk($sformatf("rr%0d_rvalid", c), 32'(ifb.rvalid_o), (c == 0) ? 32'h0 : 32'(seq_b[c-1]));
      end
      // excl_id beyond NUM_REQ: nothing granted
      @(negedge clk);
      xen_b = 1'b1; xid_b = 2'd3;
      #1;
      chk("excl3_gnt",    32'(ifb.gnt_o),    32'h0);
      chk("excl3_men",    32'(ifb.mem_en_o), 32'h0);
      chk("excl3_rvalid", 32'(ifb.rvalid_o), 32'h4);
      @(negedge clk);
      xid_b = 2'd2;
      #1;
      chk("excl2_gnt",    32'(ifb.gnt_o),    32'h4);
      chk("excl2_rvalid", 32'(ifb.rvalid_o), 32'h0);
      @(negedge clk);
      idle_all();
      #1;
      chk("excl2_rsp",    32'(ifb.rvalid_o), 32'h4);

      // ---- latency 2 back-to-back reads on instance c
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         ifc.req_i  = (k < 3) ? 2'b01 : 2'b00;
         ifc.we_i   = 2'b00;
         ifc.addr_i = {10'd0, 10'(k)};
         #1;
         chk($sformatf("l2_%0d_gnt", k),    32'(ifc.gnt_o),    (k < 3) ? 32'h1 : 32'h0);
         chk($sformatf("l2_%0d_rvalid", k), 32'(ifc.rvalid_o), (k >= 2 && k <= 4) ? 32'h1 : 32'h0);
         chk($sformatf("l2_%0d_rdata", k),  ifc.rdata_o,
             (k >= 2 && k <= 4) ? (32'hA500_0000 | 32'(k - 2)) : 32'h0);
         chk($sformatf("l2_%0d_busy", k),   32'(busy_c),       (k >= 1 && k <= 4) ? 32'h1 : 32'h0);
      end

      // ---- reset in the cycle after a grant, latency 2
      @(negedge clk);
      ifc.req_i  = 2'b01;
      ifc.addr_i = {10'd0, 10'd3};
      #1;
      chk("rm_gnt", 32'(ifc.gnt_o), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      ifc.req_i = 2'b11;
      #1;
      chk("rm_rst_gnt",    32'(ifc.gnt_o),    32'h0);
      chk("rm_rst_men",    32'(ifc.mem_en_o), 32'h0);
      chk("rm_rst_rvalid", 32'(ifc.rvalid_o), 32'h0);
      chk("rm_rst_busy",   32'(busy_c),       32'h0);
      chk("rm_rst_rdata",  ifc.rdata_o,       32'h0);
      @(negedge clk);
      rst = 1'b0;
      ifc.req_i = 2'b00;
      #1;
      chk("rm_post_rvalid", 32'(ifc.rvalid_o), 32'h0);
      chk("rm_post_busy",   32'(busy_c),       32'h0);
      @(negedge clk);
      #1;
      chk("rm_post2_rvalid", 32'(ifc.rvalid_o), 32'h0);
      @(negedge clk);
      ifc.req_i = 2'b11;
      #1;
      chk("rm_first_gnt", 32'(ifc.gnt_o), 32'h1);
      @(negedge clk);
      idle_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/accel_mem_arbiter.md
# accel_mem_arbiter

Parametrised N-requester arbiter that shares one port of the accelerator's true dual-port RAM between the CPU slave interface and one or more accelerator datapath ports. It replaces the fixed two-way `start`-driven mux with round-robin arbitration, an exclusive-owner mode, per-requester grant/response handshakes with a configurable read latency, and out-of-range address detection. The block sits between the requesters and RAM port A inside the accelerator wrapper.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..8. Index 0 is the CPU by convention.
- `ADDR_WIDTH`, 10: word address width.
- `DATA_WIDTH`, 32: data width, a multiple of 8.
- `DEPTH`, 1024: number of valid words, at most 2^ADDR_WIDTH.
- `READ_LATENCY`, 1: RAM read latency in cycles, 1 or 2.

Ports. `IDW = max(1,$clog2(NUM_REQ))`. Per-requester buses are flattened, requester i in slice i.

Clocking and reset:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.

Arbitration control:
- `excl_en` in 1: exclusive mode. Only `excl_id` may be granted.
- `excl_id` in IDW: owner in exclusive mode.

Requester side:
- `req_i` in NUM_REQ: access request.
- `we_i` in NUM_REQ: 1 = write.
- `addr_i` in NUM_REQ*ADDR_WIDTH: word address.
- `be_i` in NUM_REQ*DATA_WIDTH/8: byte enables.
- `wdata_i` in NUM_REQ*DATA_WIDTH: write data.
- `gnt_o` out NUM_REQ: one-hot grant, same cycle as the request.
- `rvalid_o` out NUM_REQ: one-hot response strobe.
- `err_o` out NUM_REQ: response error, valid with `rvalid_o`.
- `rdata_o` out DATA_WIDTH: shared read data, valid with `rvalid_o` for reads.

Memory side:
- `mem_en_o`, `mem_we_o` out 1: port enable and write enable.
- `mem_addr_o` out ADDR_WIDTH: port address.
- `mem_be_o` out DATA_WIDTH/8: port byte enables.
- `mem_wdata_o` out DATA_WIDTH: port write data.
- `mem_rdata_i` in DATA_WIDTH: port read data, READ_LATENCY cycles after enable.

Status:
- `busy_o` out 1: any response still in flight.

## Operation
- **Eligible set.**
  - With `excl_en`=1: `req_i & (1<<excl_id)`.
  - Otherwise: `req_i`.
  - `excl_id >= NUM_REQ` with `excl_en`=1 yields an empty eligible set, so nothing is granted.
- **Round-robin.** A registered pointer `rr_ptr` (IDW bits) marks the highest-priority index. Search runs `rr_ptr, rr_ptr+1, …` modulo NUM_REQ, and the first eligible index wins.
- **Pointer update.** On any grant, `rr_ptr <= (winner+1) mod NUM_REQ`. Wrap from NUM_REQ-1 goes to 0. With no grant, `rr_ptr` holds.
- **Exclusive mode.** Grants still update `rr_ptr`, so fairness resumes from the owner's successor when `excl_en` drops.
- **Address check.** A granted access with `addr >= DEPTH` is "out-of-range":
  - `gnt_o` is still asserted.
  - `mem_en_o` stays 0, so no RAM access occurs.
  - The response carries `err_o`=1 and `rdata_o`=0.
- **Memory outputs.** An in-range grant drives the winner's we/addr/be/wdata with `mem_en_o`=1. With no grant or out-of-range, all memory outputs are 0.
- **Response pipeline.** A shift register READ_LATENCY deep carries {valid, id, err, is_read}. Stage 0 loads on each grant.
  - At the last stage, `rvalid_o[id]`=1 and `err_o[id]`=err.
  - `rdata_o` = `mem_rdata_i` if is_read and !err, else 0.
- **Writes.** Writes also produce a response, with `rdata_o`=0.
- **Throughput.** One access per cycle. Back-to-back grants to the same or different requesters are legal and responses keep grant order.
- **`busy_o`.** OR of all pipeline valid bits.
- **Reset.** Asserting `rst` at any time:
  - clears `rr_ptr` to 0 and all pipeline stages;
  - drops in-flight responses, with no rvalid for them after reset;
  - forces every output to 0 while `rst`=1.

## Timing
- `gnt_o` and memory outputs are combinational from `req_i`, `excl_*`, `addr_i` and `rr_ptr`, so there are zero cycles from request to grant.
- The response arrives exactly READ_LATENCY rising edges after the granting edge. Example for READ_LATENCY=1: grant in cycle n gives rvalid in cycle n+1.
- A requester with `req_i`=1 and `gnt_o`=0 holds its request and payload stable. A request withdrawn without a grant is legal.
- Toggling `excl_en` takes effect in the same cycle, combinationally.
- Reset values are all outputs 0, `rr_ptr`=0, `busy_o`=0.
- Starvation bound: a continuously requesting eligible requester is granted within NUM_REQ cycles when `excl_en`=0.

## Test plan
1. **Simple write/read.** NUM_REQ=2, LAT=1. Req0 writes 0xDEADBEEF at addr 5 (be=4'hF), then reads addr 5 → write gnt/rvalid in cycles 0/1; read gnt in cycle 2, rvalid_o=2'b01 in cycle 3 with rdata_o=0xDEADBEEF.
2. **Round-robin fairness.** NUM_REQ=3, req_i=3'b111 held for 6 cycles from reset → gnt_o sequence 001,010,100,001,010,100; one rvalid per cycle with matching id.
3. **Exclusive mode.** excl_en=1, excl_id=1, req_i=2'b11 for 4 cycles → gnt_o=2'b10 every cycle, req0 never granted. Drop excl_en → next gnt_o=2'b01.
4. **Out-of-range.** DEPTH=42, read addr 42 → gnt=1, mem_en_o=0; one cycle later rvalid=1, err=1, rdata_o=0. Address 41 → normal access with err=0.
5. **Latency 2.** READ_LATENCY=2, reads to addrs 0,1,2 back-to-back → rvalids in cycles 2,3,4, data in order, busy_o=1 in cycles 1..4.
6. **Reset mid-operation.** Assert rst in the cycle after a grant with LAT=2 → no rvalid afterward, busy_o=0, and the first grant after release with req_i=2'b11 is 2'b01.
